// File: rtl/bilinear_lerp_pipe.sv
// -----------------------------------------------------------------------------
// bilinear_lerp_pipe
//
// Streaming bilinear interpolation datapath. Each beat carries four neighbours
// per lane (p00/p01 = row 0, p10/p11 = row 1) and a pair of weights shared by
// all lanes. Three register stages:
//   S1  horizontal lerp of both rows, exact (PIX_W+FRAC_W+1 bits)
//   S2  vertical lerp of the two row results, exact (PIX_W+2*FRAC_W+2 bits)
//   S3  optional half-LSB rounding, shift by 2*FRAC_W, saturate to PIX_W
// A beat accepted on one rising edge is visible at the output after the third
// rising edge, counting the accepting edge as the first.
//
// One global enable stalls every stage at once:
//   en = out_ready | ~out_valid, in_ready = en.
//
// Configuration macro: BILIN_ROUND_EN
//   defined   -> round-half-up in S3
//   undefined -> truncate in S3
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational on out_ready)
//   p00,p01,p10,p11     neighbours, lane i at [i*PIX_W +: PIX_W]
//   ax, ay              weights toward column 1 / row 1, 1.0 = 2^FRAC_W,
//                       values above 1.0 are clamped to 1.0
//   in_tag / out_tag    sideband tag carried with the beat
//   out_valid/out_ready output handshake
//   out_pix             interpolated pixels, same lane packing as inputs
//   clamp_cnt           saturating count of accepted beats with a clamped weight
// -----------------------------------------------------------------------------
module bilinear_lerp_pipe #(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 8,
  parameter int LANES  = 2,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] p00,
  input  logic [LANES*PIX_W-1:0] p01,
  input  logic [LANES*PIX_W-1:0] p10,
  input  logic [LANES*PIX_W-1:0] p11,
  input  logic [FRAC_W:0]        ax,
  input  logic [FRAC_W:0]        ay,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*PIX_W-1:0] out_pix,
  output logic [TAG_W-1:0]       out_tag,
  output logic [15:0]            clamp_cnt
);

  localparam int H_W = PIX_W + FRAC_W + 1;
  localparam int V_W = PIX_W + 2*FRAC_W + 2;
  localparam int R_W = V_W + 1;

  localparam logic [FRAC_W:0] ONE     = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [R_W-1:0]  PIX_MAX = R_W'({PIX_W{1'b1}});
`ifdef BILIN_ROUND_EN
  localparam logic [R_W-1:0]  HALF    = R_W'(1) << (2*FRAC_W - 1);
`else
  localparam logic [R_W-1:0]  HALF    = '0;
`endif

  // Pipeline state
  logic                   r_s1_valid, r_s2_valid, r_s3_valid;
  logic [TAG_W-1:0]       r_s1_tag, r_s2_tag, r_s3_tag;
  logic [H_W-1:0]         r_s1_t [LANES];
  logic [H_W-1:0]         r_s1_b [LANES];
  logic [FRAC_W:0]        r_s1_ay;
  logic [V_W-1:0]         r_s2_v [LANES];
  logic [LANES*PIX_W-1:0] r_s3_pix;
  logic [15:0]            r_clamp_cnt;

  // Combinational stage logic
  logic                   w_en;
  logic                   w_accept;
  logic                   w_clamp_hit;
  logic [FRAC_W:0]        w_ax, w_ay;
  logic [H_W-1:0]         w_t [LANES];
  logic [H_W-1:0]         w_b [LANES];
  logic [V_W-1:0]         w_v [LANES];
  logic [R_W-1:0]         w_r [LANES];
  logic [R_W-1:0]         w_q [LANES];
  logic [PIX_W-1:0]       w_pix [LANES];

  assign w_en        = out_ready | ~r_s3_valid;
  assign w_accept    = in_valid & w_en;
  assign w_clamp_hit = (ax > ONE) | (ay > ONE);
  assign w_ax        = (ax > ONE) ? ONE : ax;
  assign w_ay        = (ay > ONE) ? ONE : ay;

  always_comb begin
    // NOTE: every array element is written on every pass through this block,
    // so nothing here can hold a previous value and no latch is inferred.
    for (int i = 0; i < LANES; i++) begin
      // S1: the weights sum to exactly 2^FRAC_W, so the result fits H_W bits.
      w_t[i] = H_W'(p00[i*PIX_W +: PIX_W]) * H_W'(ONE - w_ax)
             + H_W'(p01[i*PIX_W +: PIX_W]) * H_W'(w_ax);
      w_b[i] = H_W'(p10[i*PIX_W +: PIX_W]) * H_W'(ONE - w_ax)
             + H_W'(p11[i*PIX_W +: PIX_W]) * H_W'(w_ax);
      // S2: same argument one level up.
      w_v[i] = V_W'(r_s1_t[i]) * V_W'(ONE - r_s1_ay)
             + V_W'(r_s1_b[i]) * V_W'(r_s1_ay);
      // S3: one extra bit so the rounding add can never wrap.
      w_r[i] = R_W'(r_s2_v[i]) + HALF;
      w_q[i] = w_r[i] >> (2*FRAC_W);
      // Unreachable with clamped weights; kept as a guard on the final width.
      w_pix[i] = (w_q[i] > PIX_MAX) ? '1 : w_q[i][PIX_W-1:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every stage reads
  // the value its predecessor held before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Clearing the datapath too (not just the valids) gives out_pix and
      // out_tag their defined reset value of zero.
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_s1_tag    <= '0;
      r_s2_tag    <= '0;
      r_s3_tag    <= '0;
      r_s1_ay     <= '0;
      r_s3_pix    <= '0;
      r_clamp_cnt <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_t[i] <= '0;
        r_s1_b[i] <= '0;
        r_s2_v[i] <= '0;
      end
    end else if (w_en) begin
      // A cycle with en high and no accepted beat loads a bubble into S1.
      r_s1_valid <= w_accept;
      r_s1_tag   <= in_tag;
      r_s1_ay    <= w_ay;
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
      r_s3_valid <= r_s2_valid;
      r_s3_tag   <= r_s2_tag;
      for (int i = 0; i < LANES; i++) begin
        r_s1_t[i]                     <= w_t[i];
        r_s1_b[i]                     <= w_b[i];
        r_s2_v[i]                     <= w_v[i];
        r_s3_pix[i*PIX_W +: PIX_W]    <= w_pix[i];
      end
      if (w_accept && w_clamp_hit && (r_clamp_cnt != 16'hFFFF)) begin
        r_clamp_cnt <= r_clamp_cnt + 16'd1;
      end
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_s3_valid;
  assign out_pix   = r_s3_pix;
  assign out_tag   = r_s3_tag;
  assign clamp_cnt = r_clamp_cnt;

endmodule

// File: tb/tb_bilinear_lerp_pipe.sv
// -----------------------------------------------------------------------------
// tb_bilinear_lerp_pipe
//
// Self-checking bench for bilinear_lerp_pipe (default parameters).
// - A scoreboard queue, fed by an arithmetic reference model on every accepted
//   beat, checks every emitted beat in order.
// - A table of hand-computed vectors checks values, latency, tag and clamp_cnt.
// - Directed sequences cover the stall window and a mid-stream reset.
// - A randomized phase exercises random valid/ready and weights above 1.0.
// Honours BILIN_ROUND_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_bilinear_lerp_pipe;

  localparam int PIX_W  = 8;
  localparam int FRAC_W = 8;
  localparam int LANES  = 2;
  localparam int TAG_W  = 4;
  localparam int LW     = LANES * PIX_W;
`ifdef BILIN_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [LW-1:0]     p00, p01, p10, p11;
  logic [FRAC_W:0]   ax, ay;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     out_pix;
  logic [TAG_W-1:0]  out_tag;
  logic [15:0]       clamp_cnt;

  bilinear_lerp_pipe #(
    .PIX_W(PIX_W), .FRAC_W(FRAC_W), .LANES(LANES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .p00(p00), .p01(p01), .p10(p10), .p11(p11),
    .ax(ax), .ay(ay), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_tag(out_tag), .clamp_cnt(clamp_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain weighted sums, one rounding, one clamp.
  function automatic logic [LW-1:0] ref_pix(input logic [LW-1:0] a00, a01, a10, a11,
                                            input logic [FRAC_W:0] wx_in, wy_in);
    longint one, wx, wy, q00, q01, q10, q11, top, bot, v, q, pmax;
    logic [LW-1:0] res;
    one  = longint'(1) << FRAC_W;
    pmax = (longint'(1) << PIX_W) - 1;
    wx   = (longint'(wx_in) > one) ? one : longint'(wx_in);
    wy   = (longint'(wy_in) > one) ? one : longint'(wy_in);
    res  = '0;
    for (int i = 0; i < LANES; i++) begin
      q00 = longint'(a00[i*PIX_W +: PIX_W]);
      q01 = longint'(a01[i*PIX_W +: PIX_W]);
      q10 = longint'(a10[i*PIX_W +: PIX_W]);
      q11 = longint'(a11[i*PIX_W +: PIX_W]);
      top = q00 * (one - wx) + q01 * wx;
      bot = q10 * (one - wx) + q11 * wx;
      v   = top * (one - wy) + bot * wy;
      if (ROUND) v = v + (one * one) / 2;
      q = v / (one * one);
      if (q > pmax) q = pmax;
      res[i*PIX_W +: PIX_W] = q[PIX_W-1:0];
    end
    return res;
  endfunction

  typedef struct {
    logic [LW-1:0]    pix;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             exp_q[$];
  logic [TAG_W-1:0] emitted[$];
  int               model_clamp = 0;

  // Scoreboard: sampled mid-cycle, reflecting the transfers of the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      model_clamp = 0;
    end else begin
      check("in_ready_rule", in_ready, out_ready || !out_valid);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_pix", out_pix, e.pix);
          check("sb_tag", out_tag, e.tag);
          emitted.push_back(out_tag);
        end
      end
      if (in_valid && in_ready) begin
        e.pix = ref_pix(p00, p01, p10, p11, ax, ay);
        e.tag = in_tag;
        exp_q.push_back(e);
        if ((int'(ax) > (1 << FRAC_W) || int'(ay) > (1 << FRAC_W)) && model_clamp < 16'hFFFF)
          model_clamp++;
      end
    end
  end

  typedef struct {
    logic [LW-1:0]    p00, p01, p10, p11;
    logic [FRAC_W:0]  ax, ay;
    logic [TAG_W-1:0] tag;
    logic [LW-1:0]    exp_pix;
    logic [15:0]      exp_clamp;
  } vec_t;

  vec_t vecs[7];

  // Drives one beat (pipeline assumed idle, out_ready high) and returns the
  // number of rising edges up to and including the one after which out_valid
  // is first seen, counting the accepting edge as 1.
  task automatic send_beat(input vec_t v, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    p00 = v.p00; p01 = v.p01; p10 = v.p10; p11 = v.p11;
    ax = v.ax; ay = v.ay; in_tag = v.tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [FRAC_W:0] rand_weight();
    if ($urandom_range(0, 7) == 0) return (FRAC_W+1)'($urandom_range(257, 511));
    return (FRAC_W+1)'($urandom_range(0, 256));
  endfunction

  initial begin
    int lat;
    int k, c;
    bit acc;
    logic [LW-1:0]    held_pix;
    logic [TAG_W-1:0] held_tag;
    logic [LW-1:0]    b00[8], b01[8], b10[8], b11[8];
    logic [FRAC_W:0]  bax[8], bay[8];

    //            p00       p01       p10       p11       ax      ay      tag    expected                            clamp
    vecs[0] = '{16'h0A0A, 16'h0000, 16'h0000, 16'h0000, 9'd0,   9'd0,   4'd3,  16'h0A0A,                           16'd0};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'hC837, 9'd256, 9'd256, 4'd5,  16'hC837,                           16'd0};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 9'd128, 9'd128, 4'd9,  ROUND ? 16'h8080 : 16'h7F7F,        16'd0};
    vecs[3] = '{16'h0505, 16'h4D4D, 16'h0505, 16'h4D4D, 9'd300, 9'd256, 4'd10, 16'h4D4D,                           16'd1};
    vecs[4] = '{16'h0505, 16'h4D4D, 16'h0505, 16'h4D4D, 9'd256, 9'd256, 4'd11, 16'h4D4D,                           16'd1};
    vecs[5] = '{16'h1E1E, 16'h0000, 16'h5A5A, 16'h0000, 9'd0,   9'd511, 4'd12, 16'h5A5A,                           16'd2};
    vecs[6] = '{16'hFF64, 16'hFFC8, 16'hFF00, 16'hFF28, 9'd64,  9'd192, 4'd14, ROUND ? 16'hFF27 : 16'hFF26,        16'd2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    p00 = '0; p01 = '0; p10 = '0; p11 = '0; ax = '0; ay = '0; in_tag = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pix",   out_pix,   '0);
    check("rst_out_tag",   out_tag,   '0);
    check("rst_clamp_cnt", clamp_cnt, '0);
    check("rst_in_ready",  in_ready,  1'b1);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors: value, latency, tag, clamp counter
    for (int i = 0; i < 7; i++) begin
      send_beat(vecs[i], lat);
      check($sformatf("tbl%0d_latency", i), lat,       3);
      check($sformatf("tbl%0d_pix", i),     out_pix,   vecs[i].exp_pix);
      check($sformatf("tbl%0d_tag", i),     out_tag,   vecs[i].tag);
      check($sformatf("tbl%0d_clamp", i),   clamp_cnt, vecs[i].exp_clamp);
    end
    @(posedge clk); #1;

    // Eight back-to-back beats with out_ready low for cycles 4..8
    for (int i = 0; i < 8; i++) begin
      b00[i] = LW'($urandom); b01[i] = LW'($urandom);
      b10[i] = LW'($urandom); b11[i] = LW'($urandom);
      bax[i] = rand_weight(); bay[i] = rand_weight();
    end
    emitted.delete();
    k = 0; c = 0;
    held_pix = '0; held_tag = '0;
    while ((k < 8 || emitted.size() < 8) && c < 200) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid  = (k < 8);
      if (k < 8) begin
        p00 = b00[k]; p01 = b01[k]; p10 = b10[k]; p11 = b11[k];
        ax = bax[k]; ay = bay[k]; in_tag = TAG_W'(k);
      end
      #1;
      if (c == 4) begin
        check("stall_in_ready",  in_ready,  1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        held_pix = out_pix;
        held_tag = out_tag;
      end
      if (c > 4 && c < 9) begin
        check("stall_hold_valid", out_valid, 1'b1);
        check("stall_hold_pix",   out_pix,   held_pix);
        check("stall_hold_tag",   out_tag,   held_tag);
      end
      if (c == 9) check("resume_in_ready", in_ready, 1'b1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("burst_count", emitted.size(), 8);
    for (int i = 0; i < 8 && i < emitted.size(); i++)
      check($sformatf("burst_order%0d", i), emitted[i], i);

    // Mid-stream reset: one beat at the output, two in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      p00 = LW'($urandom); p01 = LW'($urandom); p10 = LW'($urandom); p11 = LW'($urandom);
      ax = (i == 0) ? 9'd400 : rand_weight();
      ay = rand_weight();
      in_tag = TAG_W'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("prerst_out_valid", out_valid, 1'b1);
    check("prerst_clamp",     clamp_cnt, model_clamp);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_clamp",     clamp_cnt, '0);
    check("midrst_in_ready",  in_ready,  1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      check("postrst_idle", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    send_beat(vecs[0], lat);
    check("postrst_latency", lat,       3);
    check("postrst_pix",     out_pix,   vecs[0].exp_pix);
    check("postrst_tag",     out_tag,   vecs[0].tag);
    check("postrst_clamp",   clamp_cnt, 16'd0);
    @(posedge clk); #1;

    // Randomized traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      p00 = LW'($urandom); p01 = LW'($urandom);
      p10 = LW'($urandom); p11 = LW'($urandom);
      ax = rand_weight(); ay = rand_weight();
      in_tag = TAG_W'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty",  exp_q.size(), 0);
    check("drain_idle",   out_valid,    1'b0);
    check("random_clamp", clamp_cnt,    model_clamp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
